// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_pkg                                               |
// | Description : Shared 640x480@60 timing constants and sync bundle type.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

    localparam int c_coord_w  = 11;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_sync_dly = 1;

    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Bundle order {hs, vs, blank_n}; idle is both syncs released and blanked.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    localparam logic [2:0] c_sync_idle = 3'b110;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_delay                                               |
// | Description : Enable-gated 3-bit shift register aligning sync to colour.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vga_sync_delay #(
    parameter int         DEPTH   = 1,
    parameter logic [2:0] RST_VAL = 3'b110
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iEN,
    input  logic [2:0] data_i,
    output logic [2:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{iCLK, iRST_N, iEN};
            assign data_o   = data_i;
        end else begin : g_shift
            logic [2:0] stage_q [DEPTH];

            always_ff @(posedge iCLK) begin
                if (!iRST_N) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else if (iEN) begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                               |
// | Description : VGA raster counters, frame/line markers and delayed syncs.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter int SYNC_DLY = c_sync_dly
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iEN,
    output logic [c_coord_w-1:0] oVga_x,
    output logic [c_coord_w-1:0] oVga_y,
    output logic                 oActive,
    output logic                 oSOF,
    output logic                 oSOL,
    output logic [15:0]          oFrame_cnt,
    output logic                 oVGA_HS,
    output logic                 oVGA_VS,
    output logic                 oVGA_BLANK_N,
    output logic                 oVGA_SYNC_N
);

    localparam int c_htot = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_vtot = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [c_coord_w-1:0] c_h_last   = c_coord_w'(c_htot - 1);
    localparam logic [c_coord_w-1:0] c_v_last   = c_coord_w'(c_vtot - 1);
    localparam logic [c_coord_w-1:0] c_h_vis    = c_coord_w'(H_ACTIVE);
    localparam logic [c_coord_w-1:0] c_v_vis    = c_coord_w'(V_ACTIVE);
    localparam logic [c_coord_w-1:0] c_hs_start = c_coord_w'(H_ACTIVE + H_FP);
    localparam logic [c_coord_w-1:0] c_hs_stop  = c_coord_w'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_coord_w-1:0] c_vs_start = c_coord_w'(V_ACTIVE + V_FP);
    localparam logic [c_coord_w-1:0] c_vs_stop  = c_coord_w'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_coord_w-1:0] h_cnt_q, h_cnt_d;
    logic [c_coord_w-1:0] v_cnt_q, v_cnt_d;
    logic                 active_q, active_d;
    logic                 sof_q, sof_d;
    logic                 sol_q, sol_d;
    logic [15:0]          frame_q, frame_d;

    vga_sync_t            w_sync_raw;
    logic [2:0]           w_sync_dly;

    // Flags are derived from the next counter values so they line up with x/y.
    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        active_d = active_q;
        sof_d    = 1'b0;
        sol_d    = 1'b0;
        frame_d  = frame_q;
        if (iEN) begin
            if (h_cnt_q == c_h_last) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            active_d = (h_cnt_d < c_h_vis) && (v_cnt_d < c_v_vis);
            sol_d    = (h_cnt_d == '0) && (v_cnt_d < c_v_vis);
            sof_d    = (h_cnt_d == '0) && (v_cnt_d == '0);
            if (sof_d) begin
                frame_d = frame_q + 16'd1;
            end
        end
    end

    // Reset parks the raster on its last pixel so the first enable lands on (0,0).
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            h_cnt_q  <= c_h_last;
            v_cnt_q  <= c_v_last;
            active_q <= 1'b0;
            sof_q    <= 1'b0;
            sol_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            active_q <= active_d;
            sof_q    <= sof_d;
            sol_q    <= sol_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        w_sync_raw.hs      = !((h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_stop));
        w_sync_raw.vs      = !((v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_stop));
        w_sync_raw.blank_n = active_q;
    end

    vga_sync_delay #(
        .DEPTH   (SYNC_DLY),
        .RST_VAL (c_sync_idle)
    ) u_sync_delay (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (iEN),
        .data_i ({w_sync_raw.hs, w_sync_raw.vs, w_sync_raw.blank_n}),
        .data_o (w_sync_dly)
    );

    assign oVga_x       = h_cnt_q;
    assign oVga_y       = v_cnt_q;
    assign oActive      = active_q;
    assign oSOF         = sof_q;
    assign oSOL         = sol_q;
    assign oFrame_cnt   = frame_q;
    assign oVGA_HS      = w_sync_dly[2];
    assign oVGA_VS      = w_sync_dly[1];
    assign oVGA_BLANK_N = w_sync_dly[0];
    assign oVGA_SYNC_N  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                            |
// | Description : Raster-index reference model against a 640x480 and a tiny.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

    typedef logic [44:0] vec_t;

    logic iCLK = 1'b0;
    logic iRST_N;
    logic iEN;
    always #5 iCLK = ~iCLK;

    logic [10:0] x0, y0, x1, y1;
    logic        act0, sof0, sol0, hs0, vs0, bn0, sn0;
    logic        act1, sof1, sol1, hs1, vs1, bn1, sn1;
    logic [15:0] fc0, fc1;

    vga_timing_gen dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN),
        .oVga_x(x0), .oVga_y(y0), .oActive(act0), .oSOF(sof0), .oSOL(sol0),
        .oFrame_cnt(fc0), .oVGA_HS(hs0), .oVGA_VS(vs0), .oVGA_BLANK_N(bn0),
        .oVGA_SYNC_N(sn0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DLY(2)
    ) dut_s (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN),
        .oVga_x(x1), .oVga_y(y1), .oActive(act1), .oSOF(sof1), .oSOL(sol1),
        .oFrame_cnt(fc1), .oVGA_HS(hs1), .oVGA_VS(vs1), .oVGA_BLANK_N(bn1),
        .oVGA_SYNC_N(sn1)
    );

    int HA [2] = '{640, 8};
    int HF [2] = '{16, 2};
    int HS [2] = '{96, 3};
    int HB [2] = '{48, 2};
    int VA [2] = '{480, 4};
    int VF [2] = '{10, 1};
    int VS [2] = '{2, 2};
    int VB [2] = '{33, 1};
    int DL [2] = '{1, 2};

    // Reference state: linear raster index, frame count, pulse flags and a
    // short history of raw {hs,vs,blank_n} per pixel advance.
    int         m_pos   [2];
    int         m_frame [2];
    logic       m_sof   [2];
    logic       m_sol   [2];
    logic [2:0] m_hist  [2][4];

    int vectors     = 0;
    int miscompares = 0;

    function automatic int ht(input int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vt(input int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    function automatic logic [2:0] raw(input int d, input int p);
        int   x  = p % ht(d);
        int   y  = p / ht(d);
        logic h  = !((x >= HA[d] + HF[d]) && (x < HA[d] + HF[d] + HS[d]));
        logic v  = !((y >= VA[d] + VF[d]) && (y < VA[d] + VF[d] + VS[d]));
        logic bl = (x < HA[d]) && (y < VA[d]);
        return {h, v, bl};
    endfunction

    function automatic void model_update(input logic en, input logic rst_n);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_pos[d]   = ht(d) * vt(d) - 1;
                m_frame[d] = 0;
                m_sof[d]   = 1'b0;
                m_sol[d]   = 1'b0;
                for (int i = 0; i < 4; i++) m_hist[d][i] = 3'b110;
            end else if (en) begin
                for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
                m_hist[d][0] = raw(d, m_pos[d]);
                m_pos[d] = (m_pos[d] + 1) % (ht(d) * vt(d));
                m_sof[d] = (m_pos[d] == 0);
                m_sol[d] = (m_pos[d] % ht(d) == 0) && (m_pos[d] / ht(d) < VA[d]);
                if (m_sof[d]) m_frame[d] = (m_frame[d] + 1) % 65536;
            end else begin
                m_sof[d] = 1'b0;
                m_sol[d] = 1'b0;
            end
        end
    endfunction

    function automatic vec_t exp_vec(input int d);
        int         p  = m_pos[d];
        logic [2:0] r  = raw(d, p);
        logic [2:0] dy = (DL[d] == 0) ? r : m_hist[d][DL[d]-1];
        return {11'(p % ht(d)), 11'(p / ht(d)), r[0], m_sof[d], m_sol[d],
                16'(m_frame[d]), dy, 1'b0};
    endfunction

    function automatic vec_t act_vec(input int d);
        if (d == 0) return {x0, y0, act0, sof0, sol0, fc0, hs0, vs0, bn0, sn0};
        return {x1, y1, act1, sof1, sol1, fc1, hs1, vs1, bn1, sn1};
    endfunction

    task automatic step(input logic en, input logic rst_n);
        iEN    = en;
        iRST_N = rst_n;
        @(posedge iCLK);
        model_update(en, rst_n);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            step(1'($urandom), 1'b0);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL reset dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
                end
            end
        end
        vectors++;
        if ({x0, y0, act0, fc0, hs0, vs0, bn0} !== {11'd799, 11'd524, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got x=%0d y=%0d act=%b fc=%0d hs=%b vs=%b bn=%b", x0, y0, act0, fc0, hs0, vs0, bn0);
        end
        step(1'b1, 1'b1);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act_vec(d) !== exp_vec(d)) begin
                miscompares++;
                $display("FAIL first_pixel dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
            end
        end
        vectors++;
        if ({x0, y0, act0, sof0, sol0, fc0} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 16'd1}) begin
            miscompares++;
            $display("FAIL first_pixel_abs got x=%0d y=%0d act=%b sof=%b sol=%b fc=%0d exp 0 0 1 1 1 1", x0, y0, act0, sof0, sol0, fc0);
        end
    endtask

    task automatic test_line;
        int hs_low = 0;
        int hs_first = -1;
        int act_cnt = 0;
        step(1'b0, 1'b0);
        for (int k = 0; k < 800; k++) begin
            step(1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL line dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
                end
            end
            if (act0) act_cnt++;
            if (!hs0) begin
                if (hs_first < 0) hs_first = int'(x0);
                hs_low++;
            end
        end
        vectors++;
        if (hs_first != 657 || hs_low != 96 || act_cnt != 640) begin
            miscompares++;
            $display("FAIL line_shape got hs_first=%0d hs_low=%0d active=%0d exp 657 96 640", hs_first, hs_low, act_cnt);
        end
    endtask

    task automatic test_half_rate;
        for (int k = 0; k < 1700; k++) begin
            step(1'(k % 2 == 0), 1'b1);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL half_rate dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    task automatic test_random_enable;
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom), 1'b1);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL random_en dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        force dut.h_cnt_q = 11'd319;
        force dut.v_cnt_q = 11'd200;
        step(1'b0, 1'b1);
        release dut.h_cnt_q;
        release dut.v_cnt_q;
        step(1'b1, 1'b1);
        vectors++;
        if (x0 !== 11'd320 || y0 !== 11'd200) begin
            miscompares++;
            $display("FAIL mid_position got x=%0d y=%0d exp 320 200", x0, y0);
        end
        step(1'($urandom), 1'b0);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act_vec(d) !== exp_vec(d)) begin
                miscompares++;
                $display("FAIL mid_reset dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
            end
        end
    endtask

    task automatic test_frame_wrap;
        step(1'b0, 1'b0);
        force dut.frame_q = 16'hFFFF;
        step(1'b0, 1'b1);
        release dut.frame_q;
        m_frame[0] = 65535;
        step(1'b1, 1'b1);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act_vec(d) !== exp_vec(d)) begin
                miscompares++;
                $display("FAIL frame_wrap dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
            end
        end
        vectors++;
        if (fc0 !== 16'd0 || sof0 !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_wrap_abs got fc=%0d sof=%b exp 0 1", fc0, sof0);
        end
    endtask

    task automatic test_frame_end;
        int ens = 0;
        int vs_low = 0;
        step(1'b0, 1'b0);
        force dut.h_cnt_q = 11'd799;
        force dut.v_cnt_q = 11'd487;
        step(1'b0, 1'b1);
        release dut.h_cnt_q;
        release dut.v_cnt_q;
        m_pos[0] = 487 * 800 + 799;
        while (!sof0 && ens < 29700) begin
            step(1'b1, 1'b1);
            ens++;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL frame_end dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
                end
            end
            if (!vs0) vs_low++;
        end
        vectors++;
        if (ens != 29601 || vs_low != 1600 || fc0 !== 16'd1) begin
            miscompares++;
            $display("FAIL frame_end_abs got ens=%0d vs_low=%0d fc=%0d exp 29601 1600 1", ens, vs_low, fc0);
        end
    endtask

    task automatic test_full_frame;
        int   nsof = 0;
        int   ens  = 0;
        int   sols = 0;
        int   cyc  = 0;
        logic en;
        logic prev_sof = 1'b0;
        step(1'b0, 1'b0);
        while (nsof < 2 && cyc < 3000) begin
            en = 1'($urandom % 4 != 0);
            step(en, 1'b1);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_vec(d) !== exp_vec(d)) begin
                    miscompares++;
                    $display("FAIL full_frame dut%0d got=%h exp=%h", d, act_vec(d), exp_vec(d));
                end
            end
            vectors++;
            if (prev_sof && sof1) begin
                miscompares++;
                $display("FAIL sof_width got two consecutive oSOF cycles exp one");
            end
            prev_sof = sof1;
            if (nsof == 1 && en) ens++;
            if (sof1) nsof++;
            if (nsof == 1 && sol1) sols++;
        end
        vectors++;
        if (nsof != 2 || ens != 120 || sols != 4) begin
            miscompares++;
            $display("FAIL frame_period got sofs=%0d ens=%0d sols=%0d exp 2 120 4", nsof, ens, sols);
        end
    endtask

    initial begin
        iEN    = 1'b0;
        iRST_N = 1'b0;
        test_reset;
        test_line;
        test_half_rate;
        test_random_enable;
        test_mid_reset;
        test_frame_wrap;
        test_frame_end;
        test_full_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_DLY, 1, pixel delay on HS/VS/BLANK_N to match the downstream registered colour stage

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- iCLK, in, 1, system clock
- iRST_N, in, 1, reset; synchronous, active-low
- iEN, in, 1, pixel-clock enable; one pixel per high cycle
- oVga_x, out, 11, current horizontal count
- oVga_y, out, 11, current vertical count
- oActive, out, 1, current pixel is in the visible area
- oSOF, out, 1, start-of-frame pulse
- oSOL, out, 1, start-of-visible-line pulse
- oFrame_cnt, out, 16, frame counter
- oVGA_HS, out, 1, horizontal sync, active-low, delayed
- oVGA_VS, out, 1, vertical sync, active-low, delayed
- oVGA_BLANK_N, out, 1, visible-area flag for the DAC, delayed
- oVGA_SYNC_N, out, 1, DAC composite sync; tied 0

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-004 On an iCLK edge with iEN=1, h_cnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-005 v_cnt SHALL increment only on an h_cnt wrap; at V_TOTAL-1 it SHALL wrap to 0.
REQ-006 On an iCLK edge with iEN=0, all counters, oActive and the delay line SHALL hold their values.
REQ-007 oVga_x and oVga_y SHALL be registered copies of h_cnt and v_cnt, with zero added latency; values SHALL NOT be clamped during blanking.
REQ-008 oActive SHALL be registered and equal (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE) for the same cycle as oVga_x/oVga_y.
REQ-009 Raw HS SHALL be 0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else 1.
REQ-010 Raw VS SHALL be 0 when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else 1.
REQ-011 oVGA_HS, oVGA_VS and oVGA_BLANK_N SHALL equal raw HS, raw VS and oActive delayed by SYNC_DLY iEN-qualified shifts; SYNC_DLY=0 SHALL mean no delay.
REQ-012 oSOF SHALL be high for exactly one iCLK cycle after the update that sets the counters to (0,0), and low otherwise.
REQ-013 oSOL SHALL be high for exactly one iCLK cycle after each update that sets h_cnt=0 with v_cnt<V_ACTIVE; at (0,0), oSOF and oSOL SHALL both assert.
REQ-014 Holding iEN=1 for consecutive cycles SHALL NOT stretch oSOF or oSOL beyond one cycle.
REQ-015 oFrame_cnt SHALL increment in the same cycle that oSOF asserts and SHALL wrap from 16'hFFFF to 0.
REQ-016 oVGA_SYNC_N SHALL be constant 0.

Reset
REQ-017 While iRST_N=0 at an iCLK edge, the block SHALL set h_cnt=H_TOTAL-1 (799) and v_cnt=V_TOTAL-1 (524).
REQ-018 The same reset SHALL set oVga_x=799, oVga_y=524, oActive=0, oSOF=0, oSOL=0, oFrame_cnt=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0, and all delay stages to their idle values (HS=1, VS=1, BLANK_N=0).
REQ-019 The first iEN after reset release SHALL produce (0,0), oActive=1, oSOF=1, oSOL=1 and oFrame_cnt=1.
REQ-020 Reset asserted mid-frame SHALL take effect on the next iCLK edge regardless of iEN.

Structure
REQ-021 The timing parameters, H_TOTAL, V_TOTAL and the coordinate width (11) SHALL live in the shared package vga_timing_pkg, which the overlay stage also uses.
REQ-022 The SYNC_DLY delay line SHALL be the sub-module vga_sync_delay: a 3-bit wide, SYNC_DLY deep, enable-gated shift register with synchronous reset.

Verification
REQ-023 Reset, then iEN=1 continuously -> first cycle gives x=0, y=0, oSOF=1, oFrame_cnt=1; the next oSOF occurs exactly 420000 enabled cycles later with oFrame_cnt=2.
REQ-024 One full line with iEN=1 -> oActive=1 for x=0..639; raw HS low for x=656..751 (96 pixels); oVGA_HS low for x=657..752 when SYNC_DLY=1.
REQ-025 Full frame -> oVGA_VS low only for y=490..491; oSOL pulses exactly 480 times per frame.
REQ-026 iEN toggling 1,0,1,0 (50 MHz clock, 25 MHz pixel rate) -> counters advance every other cycle; oSOF is exactly one iCLK wide.
REQ-027 Reset asserted at (x=320, y=200) -> next cycle reads x=799, y=524, oVGA_BLANK_N=0, oVGA_HS=1, oFrame_cnt=0.
REQ-028 oFrame_cnt preset to 16'hFFFF via force, then one SOF -> oFrame_cnt=0.
